// File: rtl/blk_mem_gen_2.sv
// Read-only 1-bit collision map for a MAP_W x MAP_H playfield.
// Solid regions are fixed rectangles; out-of-range addresses read as solid.
module blk_mem_gen_2 #(
    parameter int unsigned MAP_W  = 960,
    parameter int unsigned MAP_H  = 512,
    parameter int          ADDR_W = 20
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic [ADDR_W-1:0] addra,
    output logic              douta
);

    localparam int unsigned MAP_PIXELS = MAP_W * MAP_H;

    logic [31:0] addr_ext;
    logic [31:0] pix_x;
    logic [31:0] pix_y;
    logic        in_range;
    logic        solid;
    logic        douta_d;
    logic        douta_q = 1'b0;

    // Inclusive bounds; everything is 32-bit unsigned so nothing can wrap.
    function automatic logic in_rect(
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [31:0] x_lo,
        input logic [31:0] x_hi,
        input logic [31:0] y_lo,
        input logic [31:0] y_hi
    );
        return (x >= x_lo) && (x <= x_hi) && (y >= y_lo) && (y <= y_hi);
    endfunction

    always_comb begin
        addr_ext = 32'(addra);
        in_range = addr_ext < MAP_PIXELS;
        pix_y    = addr_ext / MAP_W;
        pix_x    = addr_ext % MAP_W;
        solid    = in_rect(pix_x, pix_y, 32'd0,   32'd959, 32'd400, 32'd511)
                 | in_rect(pix_x, pix_y, 32'd300, 32'd399, 32'd300, 32'd309)
                 | in_rect(pix_x, pix_y, 32'd500, 32'd619, 32'd250, 32'd259)
                 | in_rect(pix_x, pix_y, 32'd700, 32'd739, 32'd340, 32'd399)
                 | in_rect(pix_x, pix_y, 32'd150, 32'd189, 32'd200, 32'd239);
        douta_d  = in_range ? solid : 1'b1;
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            douta_q <= 1'b0;
        end else begin
            douta_q <= douta_d;
        end
    end

    assign douta = douta_q;

endmodule

// File: tb/tb_blk_mem_gen_2.sv
// Bench for blk_mem_gen_2: directed corner cases then randomized addresses
// compared against a rectangle-list model of the collision map.
module tb_blk_mem_gen_2;

    logic        clka = 1'b0;
    logic        rsta = 1'b0;
    logic [19:0] addra = '0;
    logic        douta;

    int passed = 0;
    int total  = 0;

    blk_mem_gen_2 dut (
        .clka  (clka),
        .rsta  (rsta),
        .addra (addra),
        .douta (douta)
    );

    always #5 clka = ~clka;

    // Solid rectangles: x_lo, x_hi, y_lo, y_hi (inclusive).
    int rects [5][4] = '{
        '{0,   959, 400, 511},
        '{300, 399, 300, 309},
        '{500, 619, 250, 259},
        '{700, 739, 340, 399},
        '{150, 189, 200, 239}
    };

    function automatic logic model(input int unsigned a);
        int unsigned x, y;
        if (a >= 960 * 512) return 1'b1;
        x = a % 960;
        y = a / 960;
        for (int r = 0; r < 5; r++) begin
            if (x >= rects[r][0] && x <= rects[r][1] &&
                y >= rects[r][2] && y <= rects[r][3]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: douta=%b expected=%b", tag, obs, exp);
    endtask

    // Drive one address (and reset level), clock once, check the registered result.
    task automatic step(input string tag, input int unsigned a, input logic rst);
        logic exp;
        addra = a[19:0];
        rsta  = rst;
        exp   = rst ? 1'b0 : model(a);
        @(posedge clka);
        #1;
        check(tag, douta, exp);
    endtask

    initial begin
        int unsigned a;
        logic        r;

        #1;
        check("powerup", douta, 1'b0);

        // First edge is unreset: the lookup must already be live.
        step("free_350",      336244, 1'b0);
        step("ground_top",    384244, 1'b0);
        step("above_ground",  383284, 1'b0);
        step("platA_corner",  288300, 1'b0);
        step("platA_left",    288299, 1'b0);
        step("platA_below",   297999, 1'b0);
        step("oor_first",     491520, 1'b0);
        step("oor_max",       1048575, 1'b0);
        step("last_pixel",    491519, 1'b0);
        step("platB_corner",  250*960 + 500, 1'b0);
        step("platB_right",   259*960 + 620, 1'b0);
        step("pipe_corner",   399*960 + 739, 1'b0);
        step("pipe_above",    339*960 + 720, 1'b0);
        step("blockC_corner", 200*960 + 150, 1'b0);
        step("blockC_right",  239*960 + 190, 1'b0);
        step("origin",        0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            step("toggle", (i % 2 == 0) ? 336244 : 384244, 1'b0);
        end

        step("hold_same_0", 384244, 1'b0);
        step("reset_e1",    384244, 1'b1);
        step("reset_e2",    384244, 1'b1);
        step("reset_rel",   384244, 1'b0);
        step("hold_same_1", 384244, 1'b0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom_range(0, 1048575);
            end else begin
                a = $urandom_range(0, 511) * 960 + $urandom_range(0, 959);
            end
            r = ($urandom_range(0, 15) == 0);
            step("random", a, r);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
